// File: rtl/freq_list_scanner.sv
// freq_list_scanner: one pass over the frequency table, streaming non-zero entries as (sym, freq) pairs.
// Latency: 2 cycles from ram_rd_en to out_valid; one pair per cycle with out_ready held high.
// Backpressure: reads are throttled so that the 2-entry output buffer never overflows.
module freq_list_scanner #(
  parameter int NUM_SYMBOLS = 286,
  parameter int SYM_W       = 9,
  parameter int FREQ_W      = 24,
  parameter int SUM_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [SYM_W-1:0]  ram_rd_addr,
  input  logic [FREQ_W-1:0] ram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic [FREQ_W-1:0] out_freq,
  output logic [SYM_W:0]    nonzero_count,
  output logic [SUM_W-1:0]  total_freq
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  // One extra address bit so the "all addresses issued" value is representable.
  localparam logic [SYM_W:0] END_ADDR = (SYM_W+1)'(NUM_SYMBOLS);

  state_t              state_q, state_d;
  logic [SYM_W:0]      rd_addr_q, rd_addr_d;
  logic                inflight_q, inflight_d;
  logic [SYM_W-1:0]    inflight_addr_q, inflight_addr_d;
  logic [SYM_W-1:0]    fifo_sym_q [2];
  logic [SYM_W-1:0]    fifo_sym_d [2];
  logic [FREQ_W-1:0]   fifo_freq_q [2];
  logic [FREQ_W-1:0]   fifo_freq_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          occ_q, occ_d;
  logic [SYM_W:0]      count_q, count_d;
  logic [SUM_W-1:0]    total_q, total_d;

  logic                pop;
  logic                push;
  logic                start_scan;
  logic [SUM_W:0]      sum_ext;

  assign out_valid     = (occ_q != 2'd0);
  assign pop           = out_valid && out_ready;
  // inflight is only ever set while scanning and is cleared by reset, so stale returns are dropped.
  assign push          = inflight_q && (ram_rd_data != '0);
  assign start_scan    = (state_q == IDLE) && start;
  assign sum_ext       = {1'b0, total_q} + (SUM_W+1)'(ram_rd_data);
  assign out_sym       = out_valid ? fifo_sym_q[rd_ptr_q] : '0;
  assign out_freq      = out_valid ? fifo_freq_q[rd_ptr_q] : '0;
  assign ram_rd_addr   = rd_addr_q[SYM_W-1:0];
  assign nonzero_count = count_q;
  assign total_freq    = total_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      fifo_sym_q      <= '{default: '0};
      fifo_freq_q     <= '{default: '0};
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
      count_q         <= '0;
      total_q         <= '0;
    end else begin
      state_q         <= state_d;
      rd_addr_q       <= rd_addr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      fifo_sym_q      <= fifo_sym_d;
      fifo_freq_q     <= fifo_freq_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      count_q         <= count_d;
      total_q         <= total_d;
    end
  end

  // Next state: finish once every address is issued, returned and drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if ((rd_addr_q == END_ADDR) && !inflight_q && (occ_q == 2'd0)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: a read is issued only if its data is guaranteed a buffer slot.
  always_comb begin
    busy      = (state_q == SCAN);
    done      = (state_q == FINISH);
    ram_rd_en = (state_q == SCAN) && (rd_addr_q < END_ADDR) &&
                ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  end

  // Datapath: address counter, return tagging, output buffer and statistics.
  always_comb begin
    rd_addr_d       = rd_addr_q;
    inflight_d      = ram_rd_en;
    inflight_addr_d = ram_rd_addr;
    fifo_sym_d      = fifo_sym_q;
    fifo_freq_d     = fifo_freq_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    occ_d           = occ_q;
    count_d         = count_q;
    total_d         = total_q;
    if (start_scan) begin
      rd_addr_d  = '0;
      inflight_d = 1'b0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      occ_d      = 2'd0;
      count_d    = '0;
      total_d    = '0;
    end else begin
      if (ram_rd_en) rd_addr_d = rd_addr_q + (SYM_W+1)'(1);
      if (push) begin
        fifo_sym_d[wr_ptr_q]  = inflight_addr_q;
        fifo_freq_d[wr_ptr_q] = ram_rd_data;
        wr_ptr_d              = ~wr_ptr_q;
        count_d               = count_q + (SYM_W+1)'(1);
        total_d               = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: doc/freq_list_scanner.md
# freq_list_scanner

Consumer side of the 286-entry literal/length frequency memory. After the frequency counter has filled the table, this block scans it once and streams every non-zero entry as a (symbol, frequency) pair to the Huffman tree builder over a valid/ready handshake. It also reports the count of non-zero symbols and the total frequency.

## Interface
- NUM_SYMBOLS, 286, number of table entries scanned (addresses 0..NUM_SYMBOLS-1)
- SYM_W, 9, symbol/address width
- FREQ_W, 24, frequency entry width
- SUM_W, 32, total-frequency accumulator width
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle scan request; ignored unless idle
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- ram_rd_en  output  1  frequency RAM read strobe
- ram_rd_addr  output  SYM_W  frequency RAM read address
- ram_rd_data  input  FREQ_W  read data, valid exactly one cycle after ram_rd_en
- out_valid  output  1  out_sym/out_freq hold a pair
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_sym  output  SYM_W  symbol index of the current pair
- out_freq  output  FREQ_W  non-zero frequency of the current pair
- nonzero_count  output  SYM_W+1  number of pairs emitted in the current or last scan
- total_freq  output  SUM_W  sum of emitted frequencies, saturating at all-ones

## Operation
- States: IDLE, SCAN, FINISH.
- IDLE: busy=0. start=1 moves to SCAN, clears rd_addr, nonzero_count, total_freq, and the buffer.
- SCAN: a read is issued (ram_rd_en=1, ram_rd_addr=rd_addr, rd_addr++) when rd_addr < NUM_SYMBOLS and occupancy + inflight − pop < 2.
  - occupancy is the 2-entry output FIFO fill level. inflight is 1 if a read was issued last cycle. pop is the output handshake this cycle.
- Returned data tagged with its address:
  - Data == 0 is discarded.
  - Data != 0 is pushed into the FIFO. nonzero_count increments and total_freq adds out_freq, saturating. Both update on push.
- The FIFO can never overflow, because of the issue rule. Pairs leave the FIFO in ascending symbol order.
- out_valid = FIFO non-empty. The head holds stable while out_valid && !out_ready.
- SCAN → FINISH when rd_addr == NUM_SYMBOLS, inflight == 0 and the FIFO is empty.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- nonzero_count and total_freq hold their values until the next accepted start.
- start while busy is ignored, with no effect on the scan.
- Reset, including mid-scan:
  - state goes to IDLE, and the FIFO, inflight, rd_addr and both counters go to 0.
  - read data returning after reset is ignored.

## Timing
- Reset values: busy=0, done=0, ram_rd_en=0, ram_rd_addr=0, out_valid=0, out_sym=0, out_freq=0, nonzero_count=0, total_freq=0.
- start sampled in cycle 0: busy=1 and the first read (addr 0) in cycle 1. Data arrives in cycle 2; first out_valid in cycle 3 if entry 0 is non-zero.
- Pair latency: 2 cycles from ram_rd_en to out_valid.
- With out_ready held high, one read and one output per cycle (full throughput).
- done is asserted 2 cycles after the last event, where the last event is the final RAM return or the final output handshake, whichever is later.
- ram_rd_en is never asserted outside SCAN.

## Test plan
- All 286 entries zero, out_ready=1, start at cycle 0:
  - reads occur in cycles 1..286, out_valid never rises, done=1 in cycle 289.
  - nonzero_count=0, total_freq=0.
- All entries = index+1, out_ready=1:
  - 286 consecutive pairs (0,1)..(285,286) in cycles 3..288, done in cycle 290.
  - nonzero_count=286, total_freq=41041.
- Only entries 0, 256 and 285 non-zero (values 5, 1, 7), with out_ready toggling 1/0 each cycle:
  - exactly three pairs in order; each held stable while stalled.
  - nonzero_count=3, total_freq=13.
- out_ready=0 for 50 cycles with all entries non-zero:
  - ram_rd_en stops after 2 reads, out_valid holds (0,…); no data is lost.
  - The remaining scan completes after ready rises.
- Reset asserted during SCAN at rd_addr=100:
  - all outputs return to reset values immediately.
  - a fresh start rescans from address 0 correctly.
- Entries at FREQ_W max (0xFFFFFF) with SUM_W=24 override: total_freq saturates at 0xFFFFFF.
- start pulsed during the scan: no effect on the scan.
